// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin arbiter of NUM_CH read/write channels onto one SRAM command port
// Read data is steered back to the issuing channel through an in-order tag FIFO.
module sram_rr_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 32,
  parameter int MASK_W          = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               sram_clock,
  input  logic                               reset,
  input  logic [NUM_CH-1:0]                  req_valid,
  output logic [NUM_CH-1:0]                  req_ready,
  input  logic [NUM_CH*MASK_W-1:0]           req_mask,
  input  logic [NUM_CH*ADDR_W-1:0]           req_addr,
  input  logic [NUM_CH*DATA_W-1:0]           req_data,
  input  logic [NUM_CH-1:0]                  rsp_full,
  output logic [NUM_CH-1:0]                  rsp_valid,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic                               sram_addr_valid,
  input  logic                               sram_ready,
  output logic [ADDR_W-1:0]                  sram_addr,
  output logic [DATA_W-1:0]                  sram_data_in,
  output logic [MASK_W-1:0]                  sram_write_mask,
  input  logic [DATA_W-1:0]                  sram_data_out,
  input  logic                               sram_data_out_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_rsp
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int OS_W  = PTR_W + 1;
  localparam logic [OS_W-1:0] OS_MAX = OS_W'(MAX_OUTSTANDING);

  logic                slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]   slot_data_q, slot_data_d;
  logic [MASK_W-1:0]   slot_mask_q, slot_mask_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [CH_W-1:0]     tag_mem_q [MAX_OUTSTANDING];
  logic [CH_W-1:0]     tag_mem_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OS_W-1:0]     outstanding_q, outstanding_d;
  logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  logic [NUM_CH-1:0]   is_write;
  logic [NUM_CH-1:0]   eligible;
  logic                slot_free;
  logic                grant_found;
  logic [CH_W-1:0]     grant_idx;
  logic                grant;
  logic                grant_write;
  logic                push;
  logic                pop;

  // Reads are gated by the registered count, so a same-cycle response never unblocks a read.
  always_comb begin
    is_write = '0;
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      is_write[i] = |req_mask[i*MASK_W +: MASK_W];
      eligible[i] = req_valid[i] &&
                    (is_write[i] || (!rsp_full[i] && (outstanding_q < OS_MAX)));
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      logic [CH_W:0] cand;
      cand = {1'b0, last_grant_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!grant_found && eligible[cand[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign slot_free   = !slot_valid_q || sram_ready;
  assign grant       = slot_free && grant_found;
  assign grant_write = is_write[grant_idx];
  assign push        = grant && !grant_write;
  assign pop         = sram_data_out_valid && (outstanding_q != '0);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    slot_mask_d   = slot_mask_q;
    last_grant_d  = last_grant_q;
    tag_mem_d     = tag_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    err_d         = err_q;
    outstanding_d = outstanding_q + OS_W'(push) - OS_W'(pop);

    if (grant) begin
      slot_valid_d = 1'b1;
      slot_addr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
      slot_data_d  = grant_write ? req_data[grant_idx*DATA_W +: DATA_W] : '0;
      slot_mask_d  = grant_write ? req_mask[grant_idx*MASK_W +: MASK_W] : '0;
      last_grant_d = grant_idx;
    end else if (sram_ready) begin
      slot_valid_d = 1'b0;
    end

    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rsp_data_d = sram_data_out;
      for (int i = 0; i < NUM_CH; i++) begin
        rsp_valid_d[i] = (tag_mem_q[rd_ptr_q] == CH_W'(i));
      end
    end

    if (sram_data_out_valid && (outstanding_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge sram_clock or posedge reset) begin
    if (reset) begin
      slot_valid_q  <= 1'b0;
      slot_addr_q   <= '0;
      slot_data_q   <= '0;
      slot_mask_q   <= '0;
      last_grant_q  <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      slot_valid_q  <= slot_valid_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      slot_mask_q   <= slot_mask_d;
      last_grant_q  <= last_grant_d;
      tag_mem_q     <= tag_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      err_q         <= err_d;
    end
  end

  assign sram_addr_valid    = slot_valid_q;
  assign sram_addr          = slot_addr_q;
  assign sram_data_in       = slot_data_q;
  assign sram_write_mask    = slot_mask_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign outstanding        = outstanding_q;
  assign err_unexpected_rsp = err_q;

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Single-clock, parametrised round-robin arbiter that multiplexes NUM_CH request channels onto one SRAM command port. Each channel can issue reads or writes.
- Read data is routed back to the issuing channel using an in-order tag FIFO.
- Sits in the sram_clock domain, behind the per-channel clock-crossing FIFOs. Each channel's response FIFO supplies a prog_full indication (rsp_full).

Parameters:
NUM_CH, 4, number of request channels (2..8)
ADDR_W, 18, SRAM word address width
DATA_W, 32, SRAM data width
MASK_W, 4, byte write-mask width (DATA_W/8)
MAX_OUTSTANDING, 4, maximum reads granted but not yet returned; also the tag FIFO depth (power of 2)

Ports:
sram_clock  in  1  block clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_CH  per-channel command valid
req_ready  out  NUM_CH  per-channel command accept; at most one bit set (one-hot or zero)
req_mask  in  NUM_CH*MASK_W  per-channel byte mask, channel i at [i*MASK_W +: MASK_W]; all-zero means read, non-zero means write
req_addr  in  NUM_CH*ADDR_W  per-channel address, packed as for req_mask
req_data  in  NUM_CH*DATA_W  per-channel write data, packed as for req_mask
rsp_full  in  NUM_CH  channel response FIFO prog_full; blocks new reads for that channel
rsp_valid  out  NUM_CH  one-hot read-data write enable toward the channel response FIFOs
rsp_data  out  DATA_W  read data, shared by all channels
sram_addr_valid  out  1  command valid to SRAM controller
sram_ready  in  1  SRAM controller accepts the command
sram_addr  out  ADDR_W  command address
sram_data_in  out  DATA_W  write data (driven 0 on reads)
sram_write_mask  out  MASK_W  byte mask (0 on reads)
sram_data_out  in  DATA_W  read data from SRAM
sram_data_out_valid  in  1  read data valid
outstanding  out  clog2(MAX_OUTSTANDING)+1  reads granted and not yet returned
err_unexpected_rsp  out  1  sticky flag: data_out_valid arrived with no outstanding read

Behaviour:
- Reset (async assert, sync release): all outputs 0; tag FIFO empty; outstanding=0; round-robin pointer last_grant=NUM_CH-1, so channel 0 has first priority.
- Issue register: a single command slot. sram_addr_valid=1 while the slot is full; addr, data and mask are held stable until transfer.
- Transfer: sram_addr_valid && sram_ready. The slot is free in a cycle if it is empty or transferring that cycle.
- Eligibility of channel i: req_valid[i] && (write || (!rsp_full[i] && outstanding < MAX_OUTSTANDING)).
- Grant: when the slot is free, grant the first eligible channel searching last_grant+1, +2, ... with wrap-around.
  - req_ready[i] is combinational and asserted only for the winner; the grant is the handshake.
  - The command loads into the slot at the next edge and last_grant <= i.
  - With no eligible channel, the pointer does not move.
- Throughput: one command per cycle when sram_ready is held high. Grant-to-sram_addr_valid latency is 1 cycle.
- Reads at grant:
  - Push the channel index into the tag FIFO; outstanding increments.
  - sram_data_in and sram_write_mask are driven 0.
- Writes pass req_mask, req_addr and req_data unchanged and do not touch the tag FIFO.
- Response path:
  - When sram_data_out_valid is high, pop the tag.
  - Next cycle, drive rsp_valid[tag]=1 for exactly one cycle with rsp_data = the registered sram_data_out.
  - outstanding decrements.
- Simultaneous read grant and response: push and pop in the same cycle; outstanding is unchanged. The pushed tag is never the one popped that cycle.
- outstanding==MAX_OUTSTANDING: reads are ineligible, writes still proceed. A response in the same cycle does not unblock a read until the next cycle (eligibility uses the registered count).
- rsp_full is sampled only at grant. Responses are written unconditionally; downstream FIFOs size the prog_full threshold to cover MAX_OUTSTANDING plus 1.
- sram_data_out_valid with an empty tag FIFO: no rsp_valid is driven, err_unexpected_rsp is set to 1 and stays set until reset; outstanding does not go below 0.
- req_valid dropping after grant: no effect, because the command is already captured.
- sram_ready high while the slot is empty: ignored.
- Reset mid-operation: the slot and tag FIFO are discarded immediately and any in-flight responses are lost. Responses arriving after reset set err_unexpected_rsp.

Test Plan:
- Reset -> all outputs 0, outstanding=0. With all four channels writing continuously and sram_ready=1 -> grant order 0,1,2,3,0,... and one sram_addr_valid per cycle.
- Ch1 read addr 0x00012, sram_ready=1, data_out 0xDEADBEEF returned 3 cycles later -> sram_write_mask=0, sram_data_in=0, rsp_valid=4'b0010 one cycle after data_out_valid, rsp_data=0xDEADBEEF.
- Ch0 issues 4 reads with no responses -> outstanding=4 and a 5th ch0 read is blocked. A concurrent ch2 write (mask 4'b1111) is still granted. The first response returns outstanding to 3 and a read is granted the next cycle.
- sram_ready=0 for 5 cycles with ch3 write 0x3FFFF/0x12345678/4'b0101 -> outputs stay stable, no new req_ready. sram_ready=1 -> transfer, next channel granted the same cycle.
- Interleaved reads from ch2 then ch0, responses A then B -> rsp_valid 4'b0100 with A, then 4'b0001 with B. rsp_full[0]=1 -> ch0 reads skipped and ch1 gets the grant.
- data_out_valid with outstanding=0 -> err_unexpected_rsp=1 sticky, no rsp_valid. Async reset asserted with 2 reads outstanding -> outstanding=0 immediately, err cleared.
